// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package sync_fifo_pkg;

    // Default geometry used when the top is instantiated without overrides.
    localparam int DEFAULT_DEPTH      = 12;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Index following idx in a ring of 'depth' slots. The wrap is an explicit
    // compare, so depth does not have to be a power of two.
    function automatic int unsigned ring_next(input int unsigned idx,
                                              input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// The contents are deliberately not reset; validity is tracked by the caller.
module sync_fifo_mem #(
    parameter int DEPTH      = 12,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word in the addressed slot when a write is accepted.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Show-ahead read: the addressed slot is visible without a clock edge.
    always_comb begin
        rd_data_o = mem_q[rd_addr_i];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Requests that would overflow or underflow are silently ignored.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  wr_en,
    output logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] data_rd,
    input  logic                  rd_en,
    output logic                  fifo_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    sync_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_wr),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rd_data)
    );

    // Flags come only from the registered count, so requests never reach them combinationally.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        data_rd    = fifo_empty ? '0 : mem_rd_data;
    end

    // Accept logic, pointer advance with explicit wrap, and occupancy update.
    always_comb begin
        wr_acc   = wr_en && !fifo_full;
        rd_acc   = rd_en && !fifo_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = PTR_W'(ring_next(32'(wr_ptr_q), DEPTH));
        end
        if (rd_acc) begin
            rd_ptr_d = PTR_W'(ring_next(32'(rd_ptr_q), DEPTH));
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue immediately, without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH=12, DATA_WIDTH=8).
module tb_sync_fifo;

    localparam int DEPTH = 12;
    localparam int DW    = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_wr;
    logic          wr_en;
    logic          rd_en;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] data_rd;

    int tests_run = 0;
    int tests_failed = 0;

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_wr    (data_wr),
        .wr_en      (wr_en),
        .fifo_full  (fifo_full),
        .data_rd    (data_rd),
        .rd_en      (rd_en),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive requests, pass the rising edge, sample 1 time unit later.
    task automatic cyc(input logic w, input logic [DW-1:0] wd, input logic r);
        wr_en   = w;
        data_wr = wd;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic e, input logic f);
        chk({tag, "_empty"}, 32'(fifo_empty), 32'(e));
        chk({tag, "_full"},  32'(fifo_full),  32'(f));
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_wr = '0;

        // Reset held, then released.
        repeat (3) @(posedge clk);
        #1;
        chk_flags("rst_hold", 1'b1, 1'b0);
        chk("rst_hold_data", 32'(data_rd), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_flags("rst_rel", 1'b1, 1'b0);
        chk("rst_rel_data", 32'(data_rd), 32'h0);

        // Five entries, then asynchronous reset between edges.
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0);
        chk_flags("pre_arst", 1'b0, 1'b0);
        chk("pre_arst_data", 32'(data_rd), 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_flags("arst", 1'b1, 1'b0);
        chk("arst_data", 32'(data_rd), 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_flags("arst_rel", 1'b1, 1'b0);

        // Write burst of 15: full from the 12th write, extra writes dropped.
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, DW'(8'h20 + i), 1'b0);
            chk_flags($sformatf("wburst%0d", i), 1'b0, (i >= 11));
        end
        chk("wburst_head", 32'(data_rd), 32'h20);

        // Read burst of 15: words in order, valid before each pop edge.
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("rburst_data%0d", i), 32'(data_rd), (i < 12) ? 32'h20 + 32'(i) : 32'h0);
            cyc(1'b0, '0, 1'b1);
            chk_flags($sformatf("rburst%0d", i), (i >= 11), 1'b0);
        end

        // Wrap-around: 8 in/out, then 12 in/out across the 11->0 wrap.
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrapA_data%0d", i), 32'(data_rd), 32'h40 + 32'(i));
            cyc(1'b0, '0, 1'b1);
        end
        chk_flags("wrapA_end", 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, DW'(8'h60 + i), 1'b0);
            chk_flags($sformatf("wrapB_w%0d", i), 1'b0, (i == 11));
        end
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("wrapB_data%0d", i), 32'(data_rd), 32'h60 + 32'(i));
            cyc(1'b0, '0, 1'b1);
            chk_flags($sformatf("wrapB_r%0d", i), (i == 11), 1'b0);
        end

        // Simultaneous traffic with 5 stored: stream delayed by 5 words.
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0);
        for (int j = 0; j < 20; j++) begin
            chk($sformatf("simul_data%0d", j), 32'(data_rd), 32'h80 + 32'(j));
            cyc(1'b1, DW'(8'h85 + j), 1'b1);
        end
        chk_flags("simul_end", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("simul_drain%0d", i), 32'(data_rd), 32'h94 + 32'(i));
            cyc(1'b0, '0, 1'b1);
        end
        chk_flags("simul_drained", 1'b1, 1'b0);

        // Both requests while full: only the read goes through.
        for (int i = 0; i < 12; i++) cyc(1'b1, DW'(8'hA0 + i), 1'b0);
        chk_flags("fullboth_pre", 1'b0, 1'b1);
        cyc(1'b1, 8'hEE, 1'b1);
        chk_flags("fullboth", 1'b0, 1'b0);
        chk("fullboth_data", 32'(data_rd), 32'hA1);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("fullboth_drain%0d", i), 32'(data_rd), 32'hA1 + 32'(i));
            cyc(1'b0, '0, 1'b1);
        end
        chk_flags("fullboth_drained", 1'b1, 1'b0);

        // Both requests while empty: only the write goes through, no bypass.
        chk("emptyboth_pre", 32'(data_rd), 32'h0);
        cyc(1'b1, 8'h5A, 1'b1);
        chk_flags("emptyboth", 1'b0, 1'b0);
        chk("emptyboth_data", 32'(data_rd), 32'h5A);
        cyc(1'b0, '0, 1'b1);
        chk_flags("emptyboth_pop", 1'b1, 1'b0);
        chk("emptyboth_pop_data", 32'(data_rd), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
